// File: rtl/cond_logic_if.sv
// Decoder-to-conditional-stage signal bundle: raw strobes and ALU flags in,
// gated strobes, condition result and registered flags out.
interface cond_logic_if;
    logic [3:0] cond;
    logic [3:0] aluflags;
    logic [1:0] flagw;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       stall;
    logic       pcsrc;
    logic       regwrite;
    logic       memwrite;
    logic       condex;
    logic [3:0] flags;

    modport master (
        output cond, aluflags, flagw, pcs, regw, memw, stall,
        input  pcsrc, regwrite, memwrite, condex, flags
    );

    modport slave (
        input  cond, aluflags, flagw, pcs, regw, memw, stall,
        output pcsrc, regwrite, memwrite, condex, flags
    );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field
// against the registered flags and gates the decoder's write strobes.
module cond_logic #(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input logic          clk,
    input logic          reset_n,
    cond_logic_if.slave  bus
);

    typedef enum logic [3:0] {
        CC_EQ = 4'h0, CC_NE = 4'h1, CC_CS = 4'h2, CC_CC = 4'h3,
        CC_MI = 4'h4, CC_PL = 4'h5, CC_VS = 4'h6, CC_VC = 4'h7,
        CC_HI = 4'h8, CC_LS = 4'h9, CC_GE = 4'hA, CC_LT = 4'hB,
        CC_GT = 4'hC, CC_LE = 4'hD, CC_AL = 4'hE, CC_NV = 4'hF
    } cond_e;

    logic [3:0] flags_q;
    logic       n, z, c, v;
    logic       condex;
    logic       enable;
    cond_e      cc;

    assign {n, z, c, v} = flags_q;
    assign cc           = cond_e'(bus.cond);

    always_comb begin
        condex = 1'b1;
        case (cc)
            CC_EQ:   condex = z;
            CC_NE:   condex = ~z;
            CC_CS:   condex = c;
            CC_CC:   condex = ~c;
            CC_MI:   condex = n;
            CC_PL:   condex = ~n;
            CC_VS:   condex = v;
            CC_VC:   condex = ~v;
            CC_HI:   condex = c & ~z;
            CC_LS:   condex = ~c | z;
            CC_GE:   condex = (n == v);
            CC_LT:   condex = (n != v);
            CC_GT:   condex = ~z & (n == v);
            CC_LE:   condex = z | (n != v);
            default: condex = 1'b1;
        endcase
    end

    // Reset also kills the strobes combinationally, not just the flag state.
    assign enable       = condex & ~bus.stall & reset_n;
    assign bus.pcsrc    = bus.pcs  & enable;
    assign bus.regwrite = bus.regw & enable;
    assign bus.memwrite = bus.memw & enable;
    assign bus.condex   = condex;
    assign bus.flags    = flags_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            flags_q <= RESET_FLAGS;
        end else if (enable) begin
            if (bus.flagw[1]) flags_q[3:2] <= bus.aluflags[3:2];
            if (bus.flagw[0]) flags_q[1:0] <= bus.aluflags[1:0];
        end
    end

endmodule

// File: tb/tb_cond_logic.sv
// Bench for cond_logic: directed vector table, all cond x flag combinations,
// then random traffic against a rule-level reference model.
module tb_cond_logic;

    logic clk;
    logic reset_n;
    int   total;
    int   passed;

    cond_logic_if bus ();

    cond_logic #(.RESET_FLAGS(4'b0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [3:0] cond;
        logic [3:0] alu;
        logic [1:0] flagw;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       stall;
        logic [3:0] exp_out;   // {pcsrc, regwrite, memwrite, condex}
        logic [3:0] exp_flags; // flags after the edge
    } vec_t;

    // Condition rules: pairs of codes share a base test, odd codes invert it.
    function automatic logic ref_cond(input logic [3:0] code, input logic [3:0] f);
        logic fn, fz, fc, fv, base;
        fn = f[3]; fz = f[2]; fc = f[1]; fv = f[0];
        case (code[3:1])
            3'd0:    base = fz;
            3'd1:    base = fc;
            3'd2:    base = fn;
            3'd3:    base = fv;
            3'd4:    base = fc && !fz;
            3'd5:    base = (fn == fv);
            3'd6:    base = !fz && (fn == fv);
            default: base = 1'b1;
        endcase
        return (code[3:1] == 3'd7) ? 1'b1 : (base ^ code[0]);
    endfunction

    task automatic check(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
    endtask

    task automatic run_cycle(input vec_t vv, output logic [3:0] outs, output logic [3:0] fl);
        reset_n      = vv.rst_n;
        bus.cond     = vv.cond;
        bus.aluflags = vv.alu;
        bus.flagw    = vv.flagw;
        bus.pcs      = vv.pcs;
        bus.regw     = vv.regw;
        bus.memw     = vv.memw;
        bus.stall    = vv.stall;
        @(negedge clk);
        outs = {bus.pcsrc, bus.regwrite, bus.memwrite, bus.condex};
        @(posedge clk);
        #1;
        fl = bus.flags;
    endtask

    function automatic vec_t mk(input logic rst_n, input logic [3:0] cond, input logic [3:0] alu,
                                input logic [1:0] flagw, input logic pcs, input logic regw,
                                input logic memw, input logic stall,
                                input logic [3:0] exp_out, input logic [3:0] exp_flags);
        vec_t r;
        r.rst_n = rst_n; r.cond = cond; r.alu = alu; r.flagw = flagw;
        r.pcs = pcs; r.regw = regw; r.memw = memw; r.stall = stall;
        r.exp_out = exp_out; r.exp_flags = exp_flags;
        return r;
    endfunction

    initial begin
        vec_t       tbl[$];
        vec_t       v;
        logic [3:0] outs, fl, m_flags, exp_out, nxt;
        logic       cx, g;

        total = 0;
        passed = 0;
        reset_n = 1'b0;
        bus.cond = 4'hE; bus.aluflags = 4'h0; bus.flagw = 2'b00;
        bus.pcs = 1'b0; bus.regw = 1'b0; bus.memw = 1'b0; bus.stall = 1'b0;

        //            rst   cond  alu   fw     pcs   regw  memw  stall  out      flags
        tbl.push_back(mk(1'b0, 4'hE, 4'hF, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001, 4'h0));
        tbl.push_back(mk(1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'h0));
        tbl.push_back(mk(1'b1, 4'hE, 4'hF, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'h0));
        tbl.push_back(mk(1'b1, 4'hE, 4'h4, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'h4));
        tbl.push_back(mk(1'b1, 4'h0, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b1001, 4'h4));
        tbl.push_back(mk(1'b1, 4'h1, 4'h0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'h4));
        tbl.push_back(mk(1'b1, 4'hE, 4'h3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'h3));
        tbl.push_back(mk(1'b1, 4'hE, 4'h8, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'hB));
        tbl.push_back(mk(1'b0, 4'hE, 4'hF, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0001, 4'h0));
        tbl.push_back(mk(1'b1, 4'h0, 4'hF, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 4'h0));
        tbl.push_back(mk(1'b1, 4'hE, 4'h9, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1, 4'b0001, 4'h0));
        tbl.push_back(mk(1'b1, 4'hE, 4'h9, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0111, 4'h9));
        tbl.push_back(mk(1'b1, 4'hE, 4'h8, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'h8));
        tbl.push_back(mk(1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'h8));
        tbl.push_back(mk(1'b1, 4'hB, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'h8));
        tbl.push_back(mk(1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'h8));
        tbl.push_back(mk(1'b1, 4'hD, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'h8));
        tbl.push_back(mk(1'b1, 4'hE, 4'h9, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'h9));
        tbl.push_back(mk(1'b1, 4'hA, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'h9));
        tbl.push_back(mk(1'b1, 4'hC, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'h9));
        tbl.push_back(mk(1'b1, 4'hE, 4'h6, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 4'h6));
        tbl.push_back(mk(1'b1, 4'h8, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'h6));
        tbl.push_back(mk(1'b1, 4'h9, 4'h0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0101, 4'h6));

        @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            run_cycle(tbl[i], outs, fl);
            check("tbl_out", i, outs, tbl[i].exp_out);
            check("tbl_flags", i, fl, tbl[i].exp_flags);
        end

        // Every condition code against every flag value.
        for (int f = 0; f < 16; f++) begin
            run_cycle(mk(1'b1, 4'hE, 4'(f), 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 4'b0), outs, fl);
            check("sweep_load", f, fl, 4'(f));
            for (int c = 0; c < 16; c++) begin
                run_cycle(mk(1'b1, 4'(c), ~4'(f), 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0, 4'b0), outs, fl);
                cx = ref_cond(4'(c), 4'(f));
                check("sweep_cond", f * 16 + c, outs, {cx, cx, cx, cx});
                check("sweep_hold", f * 16 + c, fl, 4'(f));
            end
        end

        m_flags = 4'hF;
        for (int i = 0; i < 400; i++) begin
            v.rst_n = ($urandom_range(0, 15) != 0);
            v.cond  = 4'($urandom);
            v.alu   = 4'($urandom);
            case ($urandom_range(0, 2))
                0:       v.flagw = 2'b00;
                1:       v.flagw = 2'b10;
                default: v.flagw = 2'b11;
            endcase
            v.pcs   = 1'($urandom);
            v.regw  = 1'($urandom);
            v.memw  = 1'($urandom);
            v.stall = ($urandom_range(0, 3) == 0);
            v.exp_out = 4'b0;
            v.exp_flags = 4'b0;

            cx = ref_cond(v.cond, m_flags);
            g  = cx && !v.stall && v.rst_n;
            exp_out = {v.pcs && g, v.regw && g, v.memw && g, cx};
            nxt = m_flags;
            if (!v.rst_n) nxt = 4'b0000;
            else if (g) begin
                if (v.flagw[1]) nxt[3:2] = v.alu[3:2];
                if (v.flagw[0]) nxt[1:0] = v.alu[1:0];
            end

            run_cycle(v, outs, fl);
            check("rand_out", i, outs, exp_out);
            check("rand_flags", i, fl, nxt);
            m_flags = nxt;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
